// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Build option: MULDIV_EARLY_OUT_EN lets trivial operations skip the iteration phase.
package muldiv_pkg;

    // Default iteration counts: full width and word (W-variant) width.
    localparam int ITER_D = 64;
    localparam int ITER_W = 32;

    // Operation select, identical to the RV M-extension funct3 encoding.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Sign-extend the low w bits of x across the full 64 bits.
    function automatic logic [63:0] sext_w(input logic [63:0] x, input int unsigned w);
        logic [63:0] hi_mask;
        logic [5:0]  msb;
        hi_mask = {64{1'b1}} << w;
        msb     = 6'(w - 1);
        return x[msb] ? (x | hi_mask) : (x & ~hi_mask);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: operating-width values, sign bits,
// magnitudes and the divide special-case detectors.
import muldiv_pkg::*;

module muldiv_operand_prep #(
    parameter int N = ITER_D,
    parameter int W = ITER_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         wArith,
    output logic         use_w,
    output logic [N-1:0] mag_a,
    output logic [N-1:0] mag_b,
    output logic         sa,
    output logic         sb,
    output logic         is_zero_b,
    output logic         is_ovf
);

    localparam bit HAS_W = (N > W);

    logic         a_signed;
    logic         b_signed;
    logic [N-1:0] wmask;
    logic [N-1:0] a_zx, b_zx, a_sx, b_sx, a_v, b_v, min_v, ones_v;
    logic [63:0]  a_ext, b_ext;

    // Derive signedness, operating-width views and magnitudes of both operands.
    always_comb begin
        use_w    = HAS_W && wArith;
        // High-half multiplies in W mode collapse to MULW, which needs no sign handling.
        a_signed = (!use_w && (op == OP_MULH || op == OP_MULHSU)) || op == OP_DIV || op == OP_REM;
        b_signed = (!use_w && op == OP_MULH) || op == OP_DIV || op == OP_REM;

        wmask  = ~({N{1'b1}} << W);
        a_ext  = sext_w(64'(a), W);
        b_ext  = sext_w(64'(b), W);
        a_zx   = use_w ? (a & wmask) : a;
        b_zx   = use_w ? (b & wmask) : b;
        a_sx   = use_w ? a_ext[N-1:0] : a;
        b_sx   = use_w ? b_ext[N-1:0] : b;
        min_v  = use_w ? (N'(1) << (W - 1)) : (N'(1) << (N - 1));
        ones_v = use_w ? wmask : {N{1'b1}};

        sa  = a_signed && (use_w ? a[W-1] : a[N-1]);
        sb  = b_signed && (use_w ? b[W-1] : b[N-1]);
        a_v = a_signed ? a_sx : a_zx;
        b_v = b_signed ? b_sx : b_zx;

        mag_a = sa ? (~a_v + N'(1)) : a_v;
        mag_b = sb ? (~b_v + N'(1)) : b_v;

        is_zero_b = (b_zx == '0);
        is_ovf    = op[2] && a_signed && (a_zx == min_v) && (b_zx == ones_v);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Build option: MULDIV_EARLY_OUT_EN sends divide-by-zero, signed overflow and
// multiply-by-zero straight from accept to FIX; results are the same either way.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once raised,
// out_valid, result and flags stay stable until that transfer (or flush/reset).
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int N = ITER_D,
    parameter int W = ITER_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         wArith,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         zero,
    output logic         sign,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(N + 1);

    state_e         state;
    op_e            op_q;
    logic           w_q, sa_q, sb_q, dz_q, ov_q;
    logic [N-1:0]   a_q, mplier, rem, quo, dvsr, result_q;
    logic [2*N-1:0] prod, mcand;
    logic [CW-1:0]  cnt;
    logic           out_valid_q, dbz_q, ovf_q;

    logic           p_use_w, p_sa, p_sb, p_zb, p_ovf;
    logic [N-1:0]   p_mag_a, p_mag_b;
    logic           accept, early;

    logic [N:0]     trial, diff;
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quo_s, rem_s, fix_r;
    logic [63:0]    fix_ext;

    muldiv_operand_prep #(.N(N), .W(W)) u_prep (
        .a         (a),
        .b         (b),
        .op        (op),
        .wArith    (wArith),
        .use_w     (p_use_w),
        .mag_a     (p_mag_a),
        .mag_b     (p_mag_b),
        .sa        (p_sa),
        .sb        (p_sb),
        .is_zero_b (p_zb),
        .is_ovf    (p_ovf)
    );

    assign in_ready = (state == IDLE) && reset_n;
    assign accept   = in_valid && in_ready && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    // Cases whose answer is already known (override value or zero product).
    assign early = op[2] ? (p_zb || p_ovf) : ((p_mag_a == '0) || (p_mag_b == '0));
`else
    assign early = 1'b0;
`endif

    // One restoring-division step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        trial = {rem, quo[N-1]};
        diff  = trial - {1'b0, dvsr};
    end

    // Apply result signs, pick the requested field, apply overrides and W sign-extension.
    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        quo_s  = (sa_q ^ sb_q) ? -quo : quo;
        rem_s  = sa_q ? -rem : rem;
        fix_r  = '0;
        case (op_q)
            OP_MUL:                       fix_r = prod_s[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_r = w_q ? prod_s[N-1:0] : prod_s[2*N-1:N];
            OP_DIV, OP_DIVU:              fix_r = dz_q ? {N{1'b1}} : (ov_q ? a_q : quo_s);
            OP_REM, OP_REMU:              fix_r = dz_q ? a_q : (ov_q ? '0 : rem_s);
            default:                      fix_r = '0;
        endcase
        fix_ext = sext_w(64'(fix_r), W);
        if (w_q) begin
            fix_r = fix_ext[N-1:0];
        end
    end

    // Control FSM plus the iterating datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            op_q        <= OP_MUL;
            w_q         <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            a_q         <= '0;
            prod        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            cnt         <= '0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_e'(op);
                        w_q    <= p_use_w;
                        a_q    <= a;
                        sa_q   <= p_sa;
                        sb_q   <= p_sb;
                        dz_q   <= op[2] && p_zb;
                        ov_q   <= p_ovf;
                        prod   <= '0;
                        mcand  <= {{N{1'b0}}, p_mag_a};
                        mplier <= p_mag_b;
                        rem    <= '0;
                        // W dividends are pre-aligned so the top bit is always the next one in.
                        quo    <= p_use_w ? (p_mag_a << (N - W)) : p_mag_a;
                        dvsr   <= p_mag_b;
                        cnt    <= p_use_w ? CW'(W) : CW'(N);
                        state  <= early ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        rem <= diff[N] ? trial[N-1:0] : diff[N-1:0];
                        quo <= {quo[N-2:0], ~diff[N]};
                    end else begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_r;
                    dbz_q    <= dz_q;
                    ovf_q    <= ov_q;
                    state    <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign zero        = (result_q == '0);
    assign sign        = result_q[N-1];
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (N=64, W=32): directed cases, flush,
// backpressure, mid-operation reset and a short random mix.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [2:0]  op = '0;
    logic        wArith = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        div_by_zero;
    logic        overflow;
    logic        zero;
    logic        sign;
    logic        busy;
    logic [1:0]  state_dbg;

    // Scoreboard entries are {overflow, div_by_zero, result}.
    logic [65:0] exp_q[$];
    int          lat_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .wArith      (wArith),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .zero        (zero),
        .sign        (sign),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from native SystemVerilog arithmetic.
    function automatic logic [65:0] ref_model(input logic [2:0] op_v, input logic [63:0] a_v,
                                              input logic [63:0] b_v, input logic w_v);
        logic [127:0]       p;
        logic [63:0]        r;
        logic [31:0]        r32, a32, b32;
        logic signed [63:0] sa, sb;
        logic signed [31:0] swa, swb;
        logic               dz, ov;
        p = '0; r = '0; r32 = '0; dz = 1'b0; ov = 1'b0;
        a32 = a_v[31:0]; b32 = b_v[31:0];
        sa = a_v; sb = b_v; swa = a32; swb = b32;
        if (w_v) begin
            dz = op_v[2] && (b32 == 32'd0);
            case (op_v)
                3'b100: if (dz) r32 = '1;
                        else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = a32; ov = 1'b1; end
                        else r32 = swa / swb;
                3'b101: r32 = dz ? '1 : a32 / b32;
                3'b110: if (dz) r32 = a32;
                        else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = '0; ov = 1'b1; end
                        else r32 = swa % swb;
                3'b111: r32 = dz ? a32 : a32 % b32;
                default: r32 = a32 * b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            dz = op_v[2] && (b_v == 64'd0);
            case (op_v)
                3'b000: r = a_v * b_v;
                3'b001: begin p = {{64{a_v[63]}}, a_v} * {{64{b_v[63]}}, b_v}; r = p[127:64]; end
                3'b010: begin p = {{64{a_v[63]}}, a_v} * {64'd0, b_v}; r = p[127:64]; end
                3'b011: begin p = {64'd0, a_v} * {64'd0, b_v}; r = p[127:64]; end
                3'b100: if (dz) r = '1;
                        else if (a_v == 64'h8000_0000_0000_0000 && b_v == '1) begin r = a_v; ov = 1'b1; end
                        else r = sa / sb;
                3'b101: r = dz ? '1 : a_v / b_v;
                3'b110: if (dz) r = a_v;
                        else if (a_v == 64'h8000_0000_0000_0000 && b_v == '1) begin r = '0; ov = 1'b1; end
                        else r = sa % sb;
                default: r = dz ? a_v : a_v % b_v;
            endcase
        end
        return {ov, dz, r};
    endfunction

    function automatic int exp_latency(input logic [2:0] op_v, input logic [63:0] a_v,
                                       input logic [63:0] b_v, input logic w_v);
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic        az, bz;
            logic [65:0] m;
            az = w_v ? (a_v[31:0] == 32'd0) : (a_v == 64'd0);
            bz = w_v ? (b_v[31:0] == 32'd0) : (b_v == 64'd0);
            m  = ref_model(op_v, a_v, b_v, w_v);
            if (op_v[2] ? (bz || m[65]) : (az || bz)) return 2;
        end
`endif
        return w_v ? 34 : 66;
    endfunction

    // Pop the expected entry and compare latency, hold stability and final outputs.
    task automatic collect(input string name, input int hold, input int cyc);
        logic [65:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check_eq({name, ".latency"}, 64'(cyc), 64'(l));
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            check_eq({name, ".hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({name, ".hold_result"}, result, e[63:0]);
            @(negedge clk);
        end
        check_eq({name, ".result"}, result, e[63:0]);
        check_eq({name, ".div_by_zero"}, 64'(div_by_zero), 64'(e[64]));
        check_eq({name, ".overflow"}, 64'(overflow), 64'(e[65]));
        check_eq({name, ".zero"}, 64'(zero), 64'(e[63:0] == 64'd0));
        check_eq({name, ".sign"}, 64'(sign), 64'(e[63]));
        check_eq({name, ".in_ready_done"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq({name, ".valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    endtask

    // Drive one request, record its expectation, wait (bounded) for the result.
    task automatic drive_op(input string name, input logic [2:0] op_v, input logic [63:0] a_v,
                            input logic [63:0] b_v, input logic w_v, input int hold);
        int cyc;
        exp_q.push_back(ref_model(op_v, a_v, b_v, w_v));
        lat_q.push_back(exp_latency(op_v, a_v, b_v, w_v));
        @(negedge clk);
        op = op_v; a = a_v; b = b_v; wArith = w_v; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        collect(name, hold, cyc);
    endtask

    // Start a request without expecting a result (used before flush/reset).
    task automatic start_raw(input logic [2:0] op_v, input logic [63:0] a_v, input logic [63:0] b_v);
        @(negedge clk);
        op = op_v; a = a_v; b = b_v; wArith = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_silence(input string name);
        logic seen;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq({name, ".no_out_valid"}, 64'(seen), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, ".out_valid"}, 64'(out_valid), 64'd0);
        check_eq({name, ".result"}, result, 64'd0);
        check_eq({name, ".div_by_zero"}, 64'(div_by_zero), 64'd0);
        check_eq({name, ".overflow"}, 64'(overflow), 64'd0);
        check_eq({name, ".zero"}, 64'(zero), 64'd1);
        check_eq({name, ".sign"}, 64'(sign), 64'd0);
        check_eq({name, ".busy"}, 64'(busy), 64'd0);
        check_eq({name, ".in_ready_low"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        // Clock/reset
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("reset.in_ready_after", 64'(in_ready), 64'd1);

        // Directed arithmetic
        drive_op("mul_7_m3",  3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
        drive_op("mulhu_ones", 3'b011, '1, '1, 1'b0, 0);
        drive_op("mulh_ones",  3'b001, '1, '1, 1'b0, 0);
        drive_op("mulhsu_m2_3", 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 0);
        drive_op("div_m7_2",  3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 0);
        drive_op("rem_m7_2",  3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 0);
        drive_op("divu_by0",  3'b101, 64'd5, 64'd0, 1'b0, 0);
        drive_op("remu_by0",  3'b111, 64'd5, 64'd0, 1'b0, 0);

        // Reset in the middle of CALC discards the operation and clears outputs
        start_raw(3'b000, 64'd3, 64'd5);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("mid_reset.in_ready_after", 64'(in_ready), 64'd1);
        expect_silence("mid_reset");

        // Signed overflow cases, including the W form
        drive_op("div_ovf",   3'b100, 64'h8000_0000_0000_0000, '1, 1'b0, 0);
        drive_op("rem_ovf",   3'b110, 64'h8000_0000_0000_0000, '1, 1'b0, 0);
        drive_op("divw_ovf",  3'b100, 64'h0000_0001_8000_0000, '1, 1'b1, 0);
        drive_op("mulhw_as_mulw", 3'b001, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0002, 1'b1, 0);
        drive_op("mul_zero",  3'b000, 64'd0, 64'd99, 1'b0, 0);

        // Flush during CALC
        start_raw(3'b100, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        #1 check_eq("flush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_eq("flush.busy", 64'(busy), 64'd0);
        check_eq("flush.in_ready", 64'(in_ready), 64'd1);
        expect_silence("flush");

        // Backpressure: consumer stalls five cycles in DONE
        drive_op("backpressure", 3'b101, 64'd1000, 64'd7, 1'b0, 5);

        // Random mix
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                1: begin ra = 64'($urandom_range(0, 16)); rb = -64'($urandom_range(1, 5)); end
                2: rb = '0;
                3: ra = -64'($urandom_range(1, 1000));
                default: ;
            endcase
            drive_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), ra, rb,
                     1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised multiply/divide unit implementing RV64M/RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) plus W variants via wArith.
- Sits beside the single-cycle ALU in the execute stage.
- Uses a valid/ready handshake so the pipeline stalls while the unit iterates.
- Produces zero/sign flags consistent with the ALU.

Parameters:
- N, 64, operand/result width; must be 32 or 64. wArith is ignored when N=32.
- W, 32, word width for wArith operations.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; equals (state==IDLE && reset_n)
- a  in  N  operand 1 (rs1)
- b  in  N  operand 2 (rs2)
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- wArith  in  1  W-variant: operate on a[W-1:0], b[W-1:0]; sign-extend the W-bit result to N
- flush  in  1  abort current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  N  result
- div_by_zero  out  1  divide/remainder with b==0 (within the operating width)
- overflow  out  1  signed DIV/REM with MIN/-1
- zero  out  1  result==0
- sign  out  1  result[N-1]
- busy  out  1  state != IDLE

Behaviour:
- **Reset** (reset_n=0 at clk edge):
  - state IDLE; out_valid, result, div_by_zero, overflow and busy all 0.
  - zero=1 and sign=0, because both derive from result.
  - Reset mid-operation discards all work.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - On in_valid && in_ready, latch operands, op, wArith and the operand signs.
  - Latch magnitudes: negate if the operand is treated as signed. MULHSU: a signed, b unsigned.
  - Load counter = ITER (N, or W when wArith) and go to CALC.
- **CALC:** one bit per cycle; counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add on magnitudes into a 2N-bit product.
  - Divide: restoring division on magnitudes, producing quotient and remainder.
- **FIX:** single cycle, then go to DONE.
  - Apply the result sign:
    - product sign = sa^sb;
    - quotient sign = sa^sb;
    - remainder sign = sa.
  - Select the result field:
    - MUL: low half;
    - MULH*: high half;
    - DIV*: quotient;
    - REM*: remainder.
  - W ops: take bits [W-1:0] of the computed result and sign-extend to N.
  - Divide by zero override: quotient = all ones (before W sign-extension), remainder = dividend; div_by_zero=1.
  - Signed overflow (dividend = MIN of the operating width, divisor = -1) override: quotient = dividend, remainder = 0; overflow=1.
  - MULH/MULHSU/MULHU with wArith are treated as MULW.
- **DONE:**
  - out_valid=1; result and flags held stable until out_ready.
  - On out_ready, go to IDLE. No accept in the same cycle; in_ready=0 in DONE.
- **Latency:** accept edge → out_valid high ITER+2 cycles later (66 for 64-bit, 34 for W).
- **flush:**
  - Forces IDLE at the next edge; out_valid=0; no result is produced.
  - Has priority over an accept and over DONE; flush in IDLE is a no-op.
- **Unsigned ops:** no sign handling; overflow is never set.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- **Defined:** special cases skip CALC: accept → FIX → DONE, so out_valid is high 2 cycles after accept. The special cases are:
  - divide/remainder by zero;
  - signed overflow;
  - multiply with either operand zero.
- **Undefined:** all operations take the full ITER+2 latency. Results are identical in both builds.

Decomposition:
- **Package muldiv_pkg:**
  - op_e enum mirroring the funct3 encodings;
  - state_e {IDLE, CALC, FIX, DONE};
  - localparams ITER_D=N and ITER_W=W;
  - helper function sext_w().
- **Sub-module muldiv_operand_prep:** combinational.
  - Inputs: a, b, op, wArith.
  - Outputs: magnitudes, signs, is_zero_b and is_ovf.
  - Shared by the accept logic and the early-out detection.

Test Plan:
1. MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) → result 0xFFFF_FFFF_FFFF_FFEB; out_valid exactly 66 cycles after accept; sign=1.
2. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands → 0.
3. Signed division of -7 by 2: DIV → 0xFFFF_FFFF_FFFF_FFFD (-3); REM → 0xFFFF_FFFF_FFFF_FFFF (-1).
4. Divide by zero, b=0: DIVU a=5 → all ones with div_by_zero=1; REMU a=5 → 5.
5. DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000 with overflow=1; REM → 0, zero=1. DIVW a=0x0000_0001_8000_0000, b=-1 → 0xFFFF_FFFF_8000_0000 with overflow=1, latency 34.
6. Flush, backpressure and reset:
   - flush at CALC cycle 10 → busy=0 and in_ready=1 next cycle; out_valid never rises.
   - out_ready held 0 for 5 cycles in DONE → result stable throughout.
   - reset_n=0 mid-CALC → all outputs return to their reset values.
